// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter slice.
// Widths, requester ids, lock states and the registered command bundle.
package dmem_pkg;

   localparam int DATA_W = 19;
   localparam int ADDR_W = 10;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_ACC = 1'b1
   } req_id_e;

   typedef enum logic {
      FAIR = 1'b0,
      LOCK = 1'b1
   } lock_st_e;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      req_id_e           owner;
   } mem_cmd_t;

endpackage

// File: rtl/rr_lock_arbiter.sv
// Round-robin CPU/accelerator arbiter with a bounded accelerator burst lock.
// The grant is combinational; last_gnt, lock state and burst_cnt are registered.
module rr_lock_arbiter
   import dmem_pkg::*;
#(
   parameter int MAX_BURST = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic cpu_req,
   input  logic acc_req,
   input  logic acc_lock,
   output logic cpu_gnt,
   output logic acc_gnt
);

   localparam int CNT_W = $clog2(MAX_BURST + 1);

   lock_st_e         state, state_nxt;
   req_id_e          last_gnt, last_nxt;
   logic [CNT_W-1:0] burst_cnt, burst_nxt;
   logic             hold, at_max, forced;

   assign hold   = (state == LOCK) && acc_req && acc_lock;
   assign at_max = (burst_cnt == CNT_W'(MAX_BURST));
   assign forced = hold && at_max && cpu_req;

   always_comb begin
      cpu_gnt   = 1'b0;
      acc_gnt   = 1'b0;
      state_nxt = state;
      last_nxt  = last_gnt;
      burst_nxt = burst_cnt;
      if (reset_n) begin
         if (forced) begin
            cpu_gnt = 1'b1;
         end else if (hold) begin
            acc_gnt = 1'b1;
         end else if (cpu_req && acc_req) begin
            cpu_gnt = (last_gnt == REQ_ACC);
            acc_gnt = (last_gnt == REQ_CPU);
         end else begin
            cpu_gnt = cpu_req;
            acc_gnt = acc_req;
         end
      end
      if (cpu_gnt) last_nxt = REQ_CPU;
      if (acc_gnt) last_nxt = REQ_ACC;
      // a saturated burst keeps the lock until the CPU actually asks
      unique case (state)
         FAIR: begin
            if (acc_gnt && acc_lock) begin
               state_nxt = LOCK;
               burst_nxt = CNT_W'(1);
            end
         end
         LOCK: begin
            if (hold && !forced) begin
               if (!at_max) burst_nxt = burst_cnt + CNT_W'(1);
            end else begin
               state_nxt = FAIR;
               burst_nxt = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= FAIR;
         last_gnt  <= REQ_ACC;
         burst_cnt <= '0;
      end else begin
         state     <= state_nxt;
         last_gnt  <= last_nxt;
         burst_cnt <= burst_nxt;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU and the accelerator.
// Registers the winning command and steers read data back to its issuer.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              acc_req,
   input  logic              acc_we,
   input  logic [ADDR_W-1:0] acc_addr,
   input  logic [DATA_W-1:0] acc_wdata,
   input  logic              acc_lock,
   output logic              acc_gnt,
   output logic              acc_rvalid,
   output logic [DATA_W-1:0] acc_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   mem_cmd_t cmd;
   logic     xfer;
   logic     rd1, rd2;
   req_id_e  own1, own2;

   rr_lock_arbiter #(
      .MAX_BURST(MAX_BURST)
   ) u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .cpu_req (cpu_req),
      .acc_req (acc_req),
      .acc_lock(acc_lock),
      .cpu_gnt (cpu_gnt),
      .acc_gnt (acc_gnt)
   );

   assign xfer = cpu_gnt | acc_gnt;

   always_comb begin
      cmd = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata, owner: REQ_CPU};
      if (acc_gnt)
         cmd = '{we: acc_we, addr: acc_addr, wdata: acc_wdata, owner: REQ_ACC};
   end

   // owner tag rides two stages so it lines up with mem_rdata
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         rd1        <= 1'b0;
         rd2        <= 1'b0;
         own1       <= REQ_CPU;
         own2       <= REQ_CPU;
         cpu_rvalid <= 1'b0;
         acc_rvalid <= 1'b0;
         cpu_rdata  <= '0;
         acc_rdata  <= '0;
      end else begin
         mem_en <= xfer;
         mem_we <= xfer && cmd.we;
         if (xfer) begin
            mem_addr  <= cmd.addr;
            mem_wdata <= cmd.wdata;
         end
         rd1        <= xfer && !cmd.we;
         own1       <= cmd.owner;
         rd2        <= rd1;
         own2       <= own1;
         cpu_rvalid <= rd2 && (own2 == REQ_CPU);
         acc_rvalid <= rd2 && (own2 == REQ_ACC);
         if (rd2 && (own2 == REQ_CPU)) cpu_rdata <= mem_rdata;
         if (rd2 && (own2 == REQ_ACC)) acc_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of arbitration, memory and read return.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   localparam int MAXB = 8;

   logic              clk = 1'b0;
   logic              reset_n = 1'b1;
   logic              cpu_req = 1'b0, cpu_we = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic [DATA_W-1:0] cpu_wdata = '0;
   logic              acc_req = 1'b0, acc_we = 1'b0, acc_lock = 1'b0;
   logic [ADDR_W-1:0] acc_addr = '0;
   logic [DATA_W-1:0] acc_wdata = '0;
   logic              cpu_gnt, cpu_rvalid, acc_gnt, acc_rvalid;
   logic [DATA_W-1:0] cpu_rdata, acc_rdata;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic [DATA_W-1:0] fmem [1024] = '{default: '0};

   int vec = 0;
   int err = 0;

   dmem_arbiter #(.MAX_BURST(MAXB)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_gnt   (cpu_gnt),
      .cpu_rvalid(cpu_rvalid),
      .cpu_rdata (cpu_rdata),
      .acc_req   (acc_req),
      .acc_we    (acc_we),
      .acc_addr  (acc_addr),
      .acc_wdata (acc_wdata),
      .acc_lock  (acc_lock),
      .acc_gnt   (acc_gnt),
      .acc_rvalid(acc_rvalid),
      .acc_rdata (acc_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   // synchronous single-port RAM attached to the command outputs
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) fmem[mem_addr] <= mem_wdata;
         else mem_rdata <= fmem[mem_addr];
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      vec++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic              v;
      logic              we;
      logic              own;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } ent_t;

   logic [DATA_W-1:0] refm [1024] = '{default: '0};
   ent_t p1 = '0, p2 = '0, p3 = '0;
   int   m_lk = 0, m_bc = 0, m_last = 1;

   always @(negedge clk) begin
      ent_t nw;
      logic ec, ea, lock_on;
      if (!reset_n) begin
         chk("reset_ctl", {cpu_gnt, acc_gnt, cpu_rvalid, acc_rvalid, mem_en,
                           mem_we, mem_addr, mem_wdata}, 64'd0);
         chk("reset_rdata", {cpu_rdata, acc_rdata}, 64'd0);
         p1 = '0; p2 = '0; p3 = '0;
         m_lk = 0; m_bc = 0; m_last = 1;
      end else begin
         ec = 1'b0;
         ea = 1'b0;
         lock_on = (m_lk != 0) && acc_req && acc_lock;
         if (lock_on && m_bc == MAXB && cpu_req) ec = 1'b1;
         else if (lock_on) ea = 1'b1;
         else if (cpu_req && acc_req) begin
            if (m_last == 1) ec = 1'b1;
            else ea = 1'b1;
         end else begin
            ec = cpu_req;
            ea = acc_req;
         end
         chk("cpu_gnt", cpu_gnt, ec);
         chk("acc_gnt", acc_gnt, ea);
         chk("mem_en", mem_en, p1.v);
         if (p1.v) begin
            chk("mem_we", mem_we, p1.we);
            chk("mem_addr", mem_addr, p1.a);
            if (p1.we) chk("mem_wdata", mem_wdata, p1.d);
         end
         chk("cpu_rvalid", cpu_rvalid, p3.v && !p3.we && !p3.own);
         chk("acc_rvalid", acc_rvalid, p3.v && !p3.we && p3.own);
         if (p3.v && !p3.we && !p3.own) chk("cpu_rdata", cpu_rdata, p3.d);
         if (p3.v && !p3.we && p3.own) chk("acc_rdata", acc_rdata, p3.d);
         nw = '0;
         if (ec || ea) begin
            nw.v   = 1'b1;
            nw.own = ea;
            nw.we  = ea ? acc_we : cpu_we;
            nw.a   = ea ? acc_addr : cpu_addr;
            if (nw.we) begin
               nw.d = ea ? acc_wdata : cpu_wdata;
               refm[nw.a] = nw.d;
            end else begin
               nw.d = refm[nw.a];
            end
         end
         p3 = p2;
         p2 = p1;
         p1 = nw;
         if (ec) m_last = 0;
         if (ea) m_last = 1;
         if (ea && acc_lock) begin
            if (m_lk != 0) m_bc = (m_bc < MAXB) ? m_bc + 1 : MAXB;
            else begin
               m_lk = 1;
               m_bc = 1;
            end
         end else begin
            m_lk = 0;
            m_bc = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic one(input bit acc, input bit we, input int a, input int d);
      if (acc) begin
         acc_req = 1'b1; acc_we = we; acc_lock = 1'b0;
         acc_addr = ADDR_W'(a); acc_wdata = DATA_W'(d);
      end else begin
         cpu_req = 1'b1; cpu_we = we;
         cpu_addr = ADDR_W'(a); cpu_wdata = DATA_W'(d);
      end
      @(negedge clk);
      chk(acc ? "lit_acc_gnt" : "lit_cpu_gnt", acc ? acc_gnt : cpu_gnt, 64'd1);
      tick();
      cpu_req = 1'b0;
      acc_req = 1'b0;
   endtask

   function automatic logic [ADDR_W-1:0] pick_addr();
      if ($urandom_range(0, 7) == 0) return ADDR_W'(10'h3FF);
      return ADDR_W'($urandom_range(0, 15));
   endfunction

   int s4 [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};

   initial begin
      logic cg, ag;
      #2 reset_n = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;

      // store then load of address 5
      one(0, 1, 'h005, 'h12345);
      @(negedge clk);
      chk("lit_t1_mem", {mem_en, mem_we, mem_addr, mem_wdata},
          {1'b1, 1'b1, 10'h005, 19'h12345});
      chk("lit_t1_rv", {cpu_rvalid, acc_rvalid}, 64'd0);
      tick();
      one(0, 0, 'h005, 0);
      @(negedge clk);
      chk("lit_t2_rv0", cpu_rvalid, 64'd0);
      tick();
      @(negedge clk);
      chk("lit_t2_rv1", cpu_rvalid, 64'd0);
      tick();
      @(negedge clk);
      chk("lit_t2_rv2", {cpu_rvalid, acc_rvalid, cpu_rdata},
          {1'b1, 1'b0, 19'h12345});
      tick();

      // fresh reset, then continuous contention, unlocked then locked
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h001;
      acc_req = 1'b1; acc_we = 1'b0; acc_addr = 10'h002; acc_lock = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("lit_t3_alt", {cpu_gnt, acc_gnt},
             (i % 2 == 0) ? 64'd2 : 64'd1);
         tick();
      end
      acc_lock = 1'b1;
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         chk("lit_t4_burst", {cpu_gnt, acc_gnt},
             (s4[i] == 1) ? 64'd1 : 64'd2);
         tick();
      end
      cpu_req = 1'b0; acc_req = 1'b0; acc_lock = 1'b0;
      repeat (3) tick();

      // back-to-back reads from opposite ends of the array
      one(1, 1, 'h3FF, 'h7ABCD);
      one(0, 1, 'h000, 'h01234);
      one(1, 0, 'h3FF, 0);
      one(0, 0, 'h000, 0);
      @(negedge clk);
      chk("lit_t5_none", {cpu_rvalid, acc_rvalid}, 64'd0);
      tick();
      @(negedge clk);
      chk("lit_t5_acc", {cpu_rvalid, acc_rvalid, acc_rdata},
          {1'b0, 1'b1, 19'h7ABCD});
      tick();
      @(negedge clk);
      chk("lit_t5_cpu", {cpu_rvalid, acc_rvalid, cpu_rdata},
          {1'b1, 1'b0, 19'h01234});
      tick();

      // reset lands while a load is in flight
      one(0, 0, 'h005, 0);
      reset_n = 1'b0;
      cpu_req = 1'b1; acc_req = 1'b1;
      @(negedge clk);
      chk("lit_t6_out", {cpu_gnt, acc_gnt, cpu_rvalid, acc_rvalid, mem_en}, 64'd0);
      tick();
      cpu_req = 1'b0; acc_req = 1'b0;
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("lit_t6_norv", cpu_rvalid, 64'd0);
         tick();
      end
      cpu_req = 1'b1; acc_req = 1'b1;
      @(negedge clk);
      chk("lit_t6_tie", {cpu_gnt, acc_gnt}, 64'd2);
      tick();
      cpu_req = 1'b0; acc_req = 1'b0;
      repeat (3) tick();

      // randomized traffic, busy CPU first, mostly idle CPU later
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         cg = cpu_gnt;
         ag = acc_gnt;
         tick();
         if (!cpu_req || cg) begin
            cpu_req   = ($urandom_range(0, (k < 1500) ? 1 : 9) == 0);
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = pick_addr();
            cpu_wdata = DATA_W'($urandom);
         end
         if (!acc_req || ag) begin
            acc_req   = ($urandom_range(0, 3) != 0);
            acc_lock  = ($urandom_range(0, 4) != 0);
            acc_we    = 1'($urandom_range(0, 1));
            acc_addr  = pick_addr();
            acc_wdata = DATA_W'($urandom);
         end
      end
      cpu_req = 1'b0; acc_req = 1'b0;
      repeat (5) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 19-bit data memory between two requesters:
  - the CPU load/store path (LD/ST);
  - the custom-instruction accelerator port (FFT/ENC/DEC engine).
- Round-robin arbitration, with an optional bounded burst lock for the accelerator.
- Registers the memory command and routes read data back to the requester that issued it.
- Sits between the core/accelerator and the data_memory array.

Parameters:
- DATA_W, 19, data word width.
- ADDR_W, 10, word address width (1024 words).
- MAX_BURST, 8, maximum consecutive locked accelerator grants before a forced CPU turn.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; held until granted.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wdata  in  DATA_W  CPU store data.
- cpu_gnt  out  1  CPU request accepted this cycle (combinational).
- cpu_rvalid  out  1  CPU load data valid.
- cpu_rdata  out  DATA_W  CPU load data.
- acc_req, acc_we, acc_addr, acc_wdata  in  1/1/ADDR_W/DATA_W  accelerator request (same rules as the CPU port).
- acc_lock  in  1  qualifies acc_req: keep the grant on the accelerator for back-to-back accesses.
- acc_gnt, acc_rvalid, acc_rdata  out  1/1/DATA_W  accelerator grant/response.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after mem_en with mem_we=0.

Behaviour:
- Handshake: a transfer occurs at a rising edge where req && gnt.
  - req/we/addr/wdata must stay stable while req=1 and gnt=0.
  - The requester may present a new request in the cycle after a transfer.
- At most one gnt is high per cycle. gnt is combinational from req and the arbiter state, and never high without req.
- Round-robin: the last_gnt register (reset = ACC) sets priority. When both request, the one not granted last wins, so CPU wins the first tie after reset.
- Lock state machine, states FAIR and LOCK:
  - FAIR -> LOCK on an accelerator transfer with acc_lock=1; burst_cnt is loaded with 1.
  - In LOCK, the accelerator has absolute priority while acc_req && acc_lock. burst_cnt increments on each accelerator transfer.
  - LOCK -> FAIR when acc_lock=0, when acc_req=0, or when burst_cnt == MAX_BURST and cpu_req=1.
  - On the forced exit, CPU wins the next cycle.
  - burst_cnt saturates at MAX_BURST if CPU is idle; the lock then continues.
- Command pipeline: on a transfer at edge E, mem_en/mem_we/mem_addr/mem_wdata are registered and high for cycle E..E+1. mem_en=0 when no transfer.
- Read return:
  - A 1-bit owner tag is pipelined with the command.
  - At edge E+2, the owner's rvalid=1 and rdata=mem_rdata, registered, for one cycle. The other requester's rvalid stays 0.
  - Read latency is 2 cycles from the handshake edge. Stores produce no rvalid.
- Throughput: one access per cycle; reads and writes may interleave back to back with no bubbles.
- Read after write to the same address on consecutive transfers returns the new data (the memory is write-first-ordered by issue).
- Reset (async assert, sync-safe deassert):
  - All outputs go to 0; state = FAIR, burst_cnt = 0, last_gnt = ACC.
  - Reads in flight are discarded; no rvalid after reset.
- No request: gnt = 0 and mem_en = 0 the following cycle; state holds.

Decomposition:
- Shared package (dmem_pkg):
  - DATA_W and ADDR_W constants;
  - requester ID enum {REQ_CPU = 0, REQ_ACC = 1};
  - lock state enum {FAIR, LOCK}.
- Natural sub-module: rr_lock_arbiter. It holds the grant logic, last_gnt, the FAIR/LOCK state machine and burst_cnt. The top level holds the command/owner pipeline and response muxing.

Test Plan:
1. Reset, then cpu_req=1 store to addr 0x005 with data 0x12345 -> cpu_gnt same cycle; next cycle mem_en=1, mem_we=1, mem_addr=0x005, mem_wdata=0x12345; no rvalid.
2. CPU load from 0x005 after scenario 1 -> cpu_rvalid=1 with rdata=0x12345 exactly 2 cycles after the handshake edge; acc_rvalid stays 0.
3. Both requesting continuously, no lock -> grants alternate CPU, ACC, CPU, ACC starting with CPU; 4 accesses in 4 cycles.
4. acc_req=acc_lock=1 and cpu_req=1 held, MAX_BURST=8, lock established on the first ACC grant -> 8 consecutive acc_gnt, then cpu_gnt, then acc_gnt resumes.
5. Back-to-back ACC read of 0x3FF followed by a CPU read of 0x000 -> rvalid on consecutive cycles, each to its owner with the correct data.
6. reset_n asserted one cycle after a CPU load handshake -> all outputs 0 immediately; no cpu_rvalid after release; the first tie after release is granted to CPU.
